// File: rtl/ring_phase_monitor_pkg.sv
// Shared types and helpers for the ring phase monitor.
// FSM states, fault codes and one-hot/rotation utilities.
package ring_pkg;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } ring_state_t;

    localparam logic [1:0] FC_NONE   = 2'b00;
    localparam logic [1:0] FC_ONEHOT = 2'b01;
    localparam logic [1:0] FC_STEP   = 2'b10;

    // Helpers operate on a zero-extended word so one body serves any WIDTH.
    localparam int MAX_W  = 32;
    localparam int LCNT_W = 4;

    function automatic logic is_onehot(input logic [MAX_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [MAX_W-1:0] rotl1(
        input logic [MAX_W-1:0] v,
        input int               w
    );
        logic [MAX_W-1:0] mask;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - 1'b1);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/ring_phase_monitor_onehot_enc.sv
// One-hot to binary index encoder with a legality flag.
// Index is meaningful only when valid is high.
module ring_onehot_enc
    import ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // OR together the positions of all set bits; exact for one-hot input
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        valid = is_onehot(MAX_W'(vec));
    end

endmodule

// File: rtl/ring_phase_monitor.sv
// Ring counter health monitor: legality, phase, revolutions, lock/fault.
// Optional macro RING_PHASE_MONITOR_SYNC_EN adds a 2-flop input synchronizer.
module ring_phase_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int REV_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     clear_err,
    output logic [$clog2(WIDTH)-1:0] phase_idx,
    output logic                     phase_valid,
    output logic                     wrap_pulse,
    output logic [REV_W-1:0]         rev_count,
    output logic                     locked,
    output logic                     fault,
    output logic [1:0]               fault_code
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] samp;

`ifdef RING_PHASE_MONITOR_SYNC_EN
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    // Two-flop synchronizer for a ring counter in a foreign clock domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ring_in;
            sync2 <= sync1;
        end
    end

    assign samp = sync2;
`else
    assign samp = ring_in;
`endif

    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] prv;

    // Current and previous token samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= '0;
            prv <= '0;
        end else begin
            cur <= samp;
            prv <= cur;
        end
    end

    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;

    ring_onehot_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec   (cur),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    logic [MAX_W-1:0] prv_rot;
    logic             step_ok;
    logic             wrap_seen;

    assign prv_rot   = rotl1(MAX_W'(prv), WIDTH);
    assign step_ok   = (prv == '0) || (cur == prv) ||
                       (MAX_W'(cur) == prv_rot);
    assign wrap_seen = prv[WIDTH-1] & cur[0];

    ring_state_t       state_q;
    ring_state_t       state_d;
    logic [LCNT_W-1:0] lock_q;
    logic [LCNT_W-1:0] lock_d;
    logic [1:0]        code_d;
    logic              wrap_d;
    logic [REV_W-1:0]  rev_d;

    // Lock/fault next state plus registered-output next values
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        code_d  = fault_code;
        wrap_d  = 1'b0;
        rev_d   = rev_count;
        unique case (state_q)
            SYNC: begin
                if (enc_valid && step_ok) begin
                    if (lock_q + 1'b1 >= LCNT_W'(LOCK_CNT)) begin
                        state_d = LOCKED;
                        lock_d  = '0;
                    end else begin
                        lock_d = lock_q + 1'b1;
                    end
                end else begin
                    lock_d = '0;
                end
            end
            LOCKED: begin
                if (!enc_valid) begin
                    state_d = FAULT;
                    code_d  = FC_ONEHOT;
                end else if (!step_ok) begin
                    state_d = FAULT;
                    code_d  = FC_STEP;
                end else if (wrap_seen) begin
                    wrap_d = 1'b1;
                    rev_d  = rev_count + 1'b1;
                end
            end
            FAULT: begin
                if (clear_err) begin
                    state_d = SYNC;
                    lock_d  = '0;
                    code_d  = FC_NONE;
                end
            end
            default: begin
                state_d = SYNC;
                lock_d  = '0;
            end
        endcase
    end

    // FSM state, lock counter and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= SYNC;
            lock_q     <= '0;
            fault_code <= FC_NONE;
            wrap_pulse <= 1'b0;
            rev_count  <= '0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            fault_code <= code_d;
            wrap_pulse <= wrap_d;
            rev_count  <= rev_d;
        end
    end

    // Phase tracks the token in every state; index holds on illegal samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_idx   <= '0;
            phase_valid <= 1'b0;
        end else begin
            phase_valid <= enc_valid;
            if (enc_valid) begin
                phase_idx <= enc_idx;
            end
        end
    end

    assign locked = (state_q == LOCKED);
    assign fault  = (state_q == FAULT);

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench for ring_phase_monitor with an expected-output queue.
// Pipeline depth follows RING_PHASE_MONITOR_SYNC_EN.
module tb_ring_phase_monitor;

    localparam int W = 4;
`ifdef RING_PHASE_MONITOR_SYNC_EN
    localparam int D = 3;
`else
    localparam int D = 1;
`endif

    typedef struct packed {
        logic       lk;
        logic       ft;
        logic [1:0] code;
        logic [1:0] idx;
        logic       vld;
        logic       wr;
        logic [7:0] rev;
    } obs_t;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       clear_err = 1'b0;
    logic [3:0] ring_in   = 4'b0000;
    logic [1:0] phase_idx;
    logic       phase_valid;
    logic       wrap_pulse;
    logic [7:0] rev_count;
    logic       locked;
    logic       fault;
    logic [1:0] fault_code;

    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];

    logic [3:0] mp [D];
    logic [3:0] m_prv;
    int         m_st;
    int         m_cnt;
    obs_t       m_o;
    logic [3:0] last;
    logic [7:0] tgt;

    always #5 clk = ~clk;

    ring_phase_monitor #(
        .WIDTH    (4),
        .REV_W    (8),
        .LOCK_CNT (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ring_in     (ring_in),
        .clear_err   (clear_err),
        .phase_idx   (phase_idx),
        .phase_valid (phase_valid),
        .wrap_pulse  (wrap_pulse),
        .rev_count   (rev_count),
        .locked      (locked),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    function automatic obs_t observe();
        obs_t o;
        o.lk   = locked;
        o.ft   = fault;
        o.code = fault_code;
        o.idx  = phase_idx;
        o.vld  = phase_valid;
        o.wr   = wrap_pulse;
        o.rev  = rev_count;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        foreach (mp[i]) mp[i] = 4'b0000;
        m_prv = 4'b0000;
        m_st  = 0;
        m_cnt = 0;
        m_o   = '0;
        exp_q.delete();
    endtask

    // Behaviour at one clock edge, using token positions for step legality
    task automatic model_edge(input logic [3:0] r, input logic clr);
        logic [3:0] c;
        logic       oh;
        logic       ok;
        logic [3:0] nxt;
        int         p;
        c  = mp[D-1];
        oh = ($countones(c) == 1);
        ok = (m_prv == 4'b0000) || (c == m_prv);
        if ($countones(m_prv) == 1) begin
            p = 0;
            for (int i = 0; i < W; i++) if (m_prv[i]) p = i;
            nxt = 4'b0001 << ((p + 1) % W);
            if (c == nxt) ok = 1'b1;
        end
        m_o.wr  = 1'b0;
        m_o.vld = oh;
        if (oh) begin
            for (int i = 0; i < W; i++) if (c[i]) m_o.idx = 2'(i);
        end
        case (m_st)
            0: begin
                if (oh && ok) begin
                    m_cnt++;
                    if (m_cnt >= 2) begin
                        m_st  = 1;
                        m_cnt = 0;
                    end
                end else begin
                    m_cnt = 0;
                end
            end
            1: begin
                if (!oh) begin
                    m_st = 2; m_o.code = 2'b01;
                end else if (!ok) begin
                    m_st = 2; m_o.code = 2'b10;
                end else if (m_prv[W-1] && c[0]) begin
                    m_o.wr  = 1'b1;
                    m_o.rev = m_o.rev + 8'd1;
                end
            end
            default: begin
                if (clr) begin
                    m_st = 0; m_cnt = 0; m_o.code = 2'b00;
                end
            end
        endcase
        m_o.lk = (m_st == 1);
        m_o.ft = (m_st == 2);
        m_prv = c;
        for (int i = D - 1; i > 0; i--) mp[i] = mp[i-1];
        mp[0] = r;
    endtask

    task automatic step(input logic [3:0] r, input logic clr);
        obs_t e;
        ring_in   = r;
        clear_err = clr;
        last      = r;
        model_edge(r, clr);
        exp_q.push_back(m_o);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty got=0 want=1");
        end else begin
            e = exp_q.pop_front();
            chk("cycle", 32'(observe()), 32'(e));
        end
        @(negedge clk);
    endtask

    task automatic rot_from(input logic [3:0] start, input int n);
        logic [3:0] r;
        r = start;
        for (int i = 0; i < n; i++) begin
            step(r, 1'b0);
            r = {r[2:0], r[3]};
        end
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(last, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_lk"},   32'(locked),      0);
        chk({tag, "_ft"},   32'(fault),       0);
        chk({tag, "_code"}, 32'(fault_code),  0);
        chk({tag, "_idx"},  32'(phase_idx),   0);
        chk({tag, "_vld"},  32'(phase_valid), 0);
        chk({tag, "_wr"},   32'(wrap_pulse),  0);
        chk({tag, "_rev"},  32'(rev_count),   0);
    endtask

    initial begin
        model_reset();
        last = 4'b0000;
        #2 reset = 1'b0;
        #1;
        chk_zero("rst");
        @(negedge clk);
        reset = 1'b1;

        rot_from(4'b0001, 14);
        hold(2);
        chk("rot_locked", 32'(locked),    1);
        chk("rot_rev3",   32'(rev_count), 3);

        repeat (5) step(4'b0110, 1'b0);
        chk("oh_fault", 32'(fault),       1);
        chk("oh_code",  32'(fault_code),  1);
        chk("oh_vld",   32'(phase_valid), 0);
        chk("oh_rev",   32'(rev_count),   3);

        step(4'b0110, 1'b1);
        chk("clr_fault", 32'(fault),      0);
        chk("clr_code",  32'(fault_code), 0);
        chk("clr_lock",  32'(locked),     0);

        rot_from(4'b0001, 8);
        hold(2);
        chk("relock",     32'(locked),    1);
        chk("relock_rev", 32'(rev_count), 4);

        rot_from(4'b0001, 2);
        step(4'b1000, 1'b0);
        hold(4);
        chk("skip_fault", 32'(fault),      1);
        chk("skip_code",  32'(fault_code), 2);

        step(4'b1000, 1'b1);
        chk("clr2_fault", 32'(fault), 0);

        rot_from(4'b0001, 2);
        step(4'b0001, 1'b0);
        hold(4);
        chk("rev_fault", 32'(fault),      1);
        chk("rev_code",  32'(fault_code), 2);

        step(4'b0001, 1'b1);
        rot_from(4'b0010, 6);
        hold(6);
        chk("hold_lock", 32'(locked),     1);
        chk("hold_idx",  32'(phase_idx),  2);
        chk("hold_wr",   32'(wrap_pulse), 0);

        tgt = m_o.rev + 8'd2;
        rot_from(4'b1000, 8);
        hold(4);
        chk("rev_plus2", 32'(rev_count), 32'(tgt));

        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        rot_from(4'b0001, 4);
        hold(3);
        chk("post_lock", 32'(locked),    1);
        chk("post_rev",  32'(rev_count), 0);
        chk("post_idx",  32'(phase_idx), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
